// File: rtl/spi_multi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_multi_pkg: default sizing and FSM state encoding for the SPI master.
// Rev 1.0
// ----------------------------------------------------------------------------
package spi_multi_pkg;
   localparam int DEF_N_CH  = 3;
   localparam int DEF_W     = 8;
   localparam int DEF_DEPTH = 16;
   localparam int DEF_HALF  = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_HOLD   = 3'd3,
      ST_GAP    = 3'd4
   } state_t;
endpackage
`default_nettype wire

// File: rtl/spi_multi_sfifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sfifo: synchronous first-word-fall-through FIFO with fill count.
// Rev 1.0
// ----------------------------------------------------------------------------
module sfifo
   import spi_multi_pkg::*;
#(
   parameter  int W     = DEF_W,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_wr,
   input  logic [W-1:0]  i_din,
   input  logic          i_rd,
   output logic [W-1:0]  o_dout,
   output logic [CW-1:0] o_count
);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_full;
   logic          w_empty;
   logic          w_do_wr;
   logic          w_do_rd;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_do_wr = i_wr && !w_full;
   assign w_do_rd = i_rd && !w_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_wr) r_wptr <= r_wptr + 1'b1;
         if (w_do_rd) r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CW'(w_do_wr) - CW'(w_do_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_wr) r_mem[r_wptr] <= i_din;
   end

   // Empty FIFO presents zero so the head output is clean after reset.
   assign o_dout  = w_empty ? '0 : r_mem[r_rptr];
   assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/spi_multi.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_multi: mode-0 SPI master sharing one bus among N_CH slaves, per-channel
// TX/RX FIFOs and round-robin channel arbitration.  Rev 1.0
// ----------------------------------------------------------------------------
module spi_multi
   import spi_multi_pkg::*;
#(
   parameter int N_CH  = DEF_N_CH,
   parameter int W     = DEF_W,
   parameter int DEPTH = DEF_DEPTH,
   parameter int HALF  = DEF_HALF
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [W-1:0]      m_din,
   input  logic [N_CH-1:0]   m_wrreq_bus,
   output logic [N_CH*W-1:0] s_dout_bus,
   output logic [N_CH*W-1:0] len_bus,
   output logic [N_CH-1:0]   have_msg_bus,
   input  logic [N_CH-1:0]   s_rdreq_bus,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [N_CH-1:0]   n_cs_bus,
   output logic [1:0]        my_select
);
   localparam int CNTW = $clog2(DEPTH) + 1;
   localparam int TW   = $clog2(2 * HALF) + 1;
   localparam int BW   = $clog2(W) + 1;

   state_t          r_state;
   logic [TW-1:0]   r_tcnt;
   logic [BW-1:0]   r_bits;
   logic [1:0]      r_sel;
   logic            r_sclk;
   logic            r_mosi;
   logic [N_CH-1:0] r_ncs;
   logic [W-1:0]    r_txsh;
   logic [W-2:0]    r_rxsh;

   logic [W-1:0]    w_tx_dout [N_CH];
   logic [CNTW-1:0] w_tx_cnt  [N_CH];
   logic [CNTW-1:0] w_rx_cnt  [N_CH];
   logic [N_CH-1:0] w_tx_nempty;
   logic [N_CH-1:0] w_tx_rd;
   logic [N_CH-1:0] w_rx_wr;
   logic [W-1:0]    w_rx_din;
   logic [1:0]      w_pick;
   logic            w_tick;
   logic            w_rise;
   logic            w_fall;
   logic            w_busy;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      sfifo #(.W(W), .DEPTH(DEPTH)) u_tx (
         .clk     (clk),
         .rst     (n_rst),
         .i_wr    (m_wrreq_bus[i]),
         .i_din   (m_din),
         .i_rd    (w_tx_rd[i]),
         .o_dout  (w_tx_dout[i]),
         .o_count (w_tx_cnt[i])
      );
      sfifo #(.W(W), .DEPTH(DEPTH)) u_rx (
         .clk     (clk),
         .rst     (n_rst),
         .i_wr    (w_rx_wr[i]),
         .i_din   (w_rx_din),
         .i_rd    (s_rdreq_bus[i]),
         .o_dout  (s_dout_bus[W*i +: W]),
         .o_count (w_rx_cnt[i])
      );
      assign w_tx_nempty[i]     = (w_tx_cnt[i] != '0);
      assign len_bus[W*i +: W]  = W'(w_rx_cnt[i]);
      assign have_msg_bus[i]    = (w_rx_cnt[i] != '0) && !(w_busy && (r_sel == 2'(i)));
   end

   assign w_busy   = (r_state == ST_SELECT) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);
   assign w_tick   = (r_state == ST_GAP) ? (r_tcnt == TW'(2 * HALF - 1))
                                         : (r_tcnt == TW'(HALF - 1));
   assign w_rise   = w_tick && ((r_state == ST_SELECT) || ((r_state == ST_SHIFT) && !r_sclk));
   assign w_fall   = w_tick && (r_state == ST_SHIFT) && r_sclk;
   assign w_rx_din = {r_rxsh, miso};

   // Round robin: the channel right after the last selected one has priority.
   always_comb begin
      w_pick = r_sel;
      for (int k = N_CH; k >= 1; k--) begin
         if (w_tx_nempty[(int'(r_sel) + k) % N_CH]) w_pick = 2'((int'(r_sel) + k) % N_CH);
      end
   end

   always_comb begin
      w_tx_rd = '0;
      w_rx_wr = '0;
      if ((r_state == ST_IDLE) && (|w_tx_nempty)) w_tx_rd[w_pick] = 1'b1;
      if (w_fall && (r_bits == BW'(W)) && w_tx_nempty[r_sel]) w_tx_rd[r_sel] = 1'b1;
      if (w_rise && (r_bits == BW'(W - 1))) w_rx_wr[r_sel] = 1'b1;
   end

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         r_state <= ST_IDLE;
         r_tcnt  <= '0;
         r_bits  <= '0;
         r_sel   <= '0;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
         r_ncs   <= '1;
         r_txsh  <= '0;
         r_rxsh  <= '0;
      end else begin
         r_tcnt <= ((r_state == ST_IDLE) || w_tick) ? '0 : r_tcnt + 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (|w_tx_nempty) begin
                  r_sel   <= w_pick;
                  r_ncs   <= ~(N_CH'(1) << w_pick);
                  r_txsh  <= w_tx_dout[w_pick];
                  r_mosi  <= w_tx_dout[w_pick][W-1];
                  r_bits  <= '0;
                  r_state <= ST_SELECT;
               end
            end
            ST_SELECT, ST_SHIFT: begin
               if (w_rise) begin
                  r_sclk  <= 1'b1;
                  r_rxsh  <= {r_rxsh[W-3:0], miso};
                  r_bits  <= r_bits + 1'b1;
                  r_state <= ST_SHIFT;
               end else if (w_fall) begin
                  r_sclk <= 1'b0;
                  if (r_bits == BW'(W)) begin
                     // Byte boundary: continue back-to-back if more data is queued.
                     if (w_tx_nempty[r_sel]) begin
                        r_txsh <= w_tx_dout[r_sel];
                        r_mosi <= w_tx_dout[r_sel][W-1];
                        r_bits <= '0;
                     end else begin
                        r_state <= ST_HOLD;
                     end
                  end else begin
                     r_txsh <= r_txsh << 1;
                     r_mosi <= r_txsh[W-2];
                  end
               end
            end
            ST_HOLD: begin
               if (w_tick) begin
                  r_ncs   <= '1;
                  r_mosi  <= 1'b0;
                  r_state <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (w_tick) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign sclk      = r_sclk;
   assign mosi      = r_mosi;
   assign n_cs_bus  = r_ncs;
   assign my_select = r_sel;
endmodule
`default_nettype wire

// File: tb/tb_spi_multi.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spi_multi: randomized bench for spi_multi with a bus-level slave monitor
// and queue-based FIFO reference model.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_spi_multi;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        n_rst;
   logic [7:0]  m_din;
   logic [2:0]  m_wrreq_bus;
   logic [23:0] s_dout_bus;
   logic [23:0] len_bus;
   logic [2:0]  have_msg_bus;
   logic [2:0]  s_rdreq_bus;
   logic        sclk;
   logic        mosi;
   logic        miso;
   logic [2:0]  n_cs_bus;
   logic [1:0]  my_select;

   spi_multi dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .m_din        (m_din),
      .m_wrreq_bus  (m_wrreq_bus),
      .s_dout_bus   (s_dout_bus),
      .len_bus      (len_bus),
      .have_msg_bus (have_msg_bus),
      .s_rdreq_bus  (s_rdreq_bus),
      .sclk         (sclk),
      .mosi         (mosi),
      .miso         (miso),
      .n_cs_bus     (n_cs_bus),
      .my_select    (my_select)
   );

   always #5 clk = ~clk;

   typedef logic [7:0] byte_q_t[$];
   byte_q_t tx_q [3];
   byte_q_t rx_q [3];
   int serve_log[$];
   int burst_log[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Slave side: new miso bit whenever SCLK is low.
   always @(negedge clk) begin
      if (!sclk) miso = 1'($urandom);
   end

   // Bus monitor: reconstructs bytes from SCLK rising edges.
   logic [7:0] mo_sh, mi_sh;
   int bitc, edges, cur_ch;
   logic prev_sclk;
   logic [2:0] prev_ncs;
   always @(negedge clk) begin
      if (n_rst) begin
         bitc = 0; edges = 0; prev_sclk = 1'b0; prev_ncs = 3'b111;
      end else begin
         if (prev_ncs == 3'b111 && n_cs_bus != 3'b111) begin
            for (int c = 0; c < 3; c++) if (!n_cs_bus[c]) cur_ch = c;
            serve_log.push_back(cur_ch);
            bitc = 0; edges = 0;
         end
         if (prev_ncs != 3'b111 && n_cs_bus == 3'b111) burst_log.push_back(edges);
         if (sclk && !prev_sclk) begin
            check("one_cs", $countones(~n_cs_bus), 1);
            edges++;
            mo_sh = {mo_sh[6:0], mosi};
            mi_sh = {mi_sh[6:0], miso};
            bitc++;
            if (bitc == 8) begin
               bitc = 0;
               if (tx_q[cur_ch].size() == 0) check("mosi_extra", 1, 0);
               else check("mosi_byte", mo_sh, tx_q[cur_ch].pop_front());
               if (rx_q[cur_ch].size() < DEPTH) rx_q[cur_ch].push_back(mi_sh);
            end
         end
         prev_sclk = sclk;
         prev_ncs  = n_cs_bus;
      end
   end

   task automatic wr(input logic [2:0] mask, input logic [7:0] val);
      @(negedge clk);
      m_din = val;
      m_wrreq_bus = mask;
      for (int c = 0; c < 3; c++)
         if (mask[c] && tx_q[c].size() < DEPTH) tx_q[c].push_back(val);
   endtask

   task automatic wr_end();
      @(negedge clk);
      m_wrreq_bus = '0;
   endtask

   task automatic wait_idle();
      int cyc = 0;
      while (cyc < 4000 && !(tx_q[0].size() == 0 && tx_q[1].size() == 0 &&
                             tx_q[2].size() == 0 && n_cs_bus == 3'b111)) begin
         @(negedge clk);
         cyc++;
      end
      check("idle_timeout", 32'(cyc < 4000), 1);
      repeat (10) @(negedge clk);
   endtask

   task automatic drain(input int ch);
      while (rx_q[ch].size() != 0) begin
         @(negedge clk);
         check("rx_len", len_bus[ch*8 +: 8], rx_q[ch].size());
         check("rx_data", s_dout_bus[ch*8 +: 8], rx_q[ch].pop_front());
         s_rdreq_bus = 3'(1 << ch);
      end
      @(negedge clk);
      s_rdreq_bus = '0;
      check("rx_len_end", len_bus[ch*8 +: 8], 0);
      check("have_msg_end", have_msg_bus[ch], 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int started;
      n_rst = 1'b1; m_din = '0; m_wrreq_bus = '0; s_rdreq_bus = '0; miso = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_ncs", n_cs_bus, 3'b111);
      check("rst_sel", my_select, 0);
      check("rst_len", len_bus, 0);
      check("rst_have", have_msg_bus, 0);
      check("rst_dout", s_dout_bus, 0);
      n_rst = 1'b0;
      repeat (2) @(negedge clk);

      // Six-byte burst on channel 1.
      for (int b = 1; b <= 6; b++) wr(3'b010, 8'(b));
      wr_end();
      wait_idle();
      check("a_serve_n", serve_log.size(), 1);
      if (serve_log.size() >= 1) check("a_serve", serve_log[0], 1);
      if (burst_log.size() >= 1) check("a_burst", burst_log[0], 48);
      check("a_sel", my_select, 1);
      check("a_len", len_bus[15:8], 6);
      check("a_have", have_msg_bus[1], 1);
      drain(1);

      // Simultaneous ch0/ch2 request with my_select=1.
      serve_log.delete(); burst_log.delete();
      wr(3'b101, 8'($urandom));
      wr_end();
      started = 0;
      for (int k = 0; k < 3 && started == 0; k++) begin
         if (n_cs_bus != 3'b111) started = 1;
         else @(negedge clk);
      end
      check("b_start_lat", started, 1);
      wait_idle();
      check("b_serve_n", serve_log.size(), 2);
      if (serve_log.size() >= 2) begin
         check("b_first", serve_log[0], 2);
         check("b_second", serve_log[1], 0);
      end
      check("b_sel", my_select, 0);
      drain(0); drain(2);

      // ch2 writes arrive while ch1 is mid-burst.
      serve_log.delete(); burst_log.delete();
      for (int b = 0; b < 6; b++) wr(3'b010, 8'($urandom));
      wr_end();
      repeat (20) @(negedge clk);
      for (int b = 10; b <= 13; b++) wr(3'b100, 8'(b));
      wr_end();
      wait_idle();
      check("c_serve_n", serve_log.size(), 2);
      if (serve_log.size() >= 2) begin
         check("c_first", serve_log[0], 1);
         check("c_second", serve_log[1], 2);
      end
      if (burst_log.size() >= 2) begin
         check("c_burst1", burst_log[0], 48);
         check("c_burst2", burst_log[1], 32);
      end
      drain(1); drain(2);

      // TX overflow on ch1 while ch0 holds the bus, then RX overflow.
      burst_log.delete();
      wr(3'b001, 8'($urandom));
      for (int b = 0; b < DEPTH + 1; b++) wr(3'b010, 8'($urandom));
      wr_end();
      wait_idle();
      check("d_len", len_bus[15:8], DEPTH);
      if (burst_log.size() >= 1) check("d_burst", burst_log[burst_log.size()-1], 8 * DEPTH);
      wr(3'b010, 8'($urandom));
      wr(3'b010, 8'($urandom));
      wr_end();
      wait_idle();
      check("d_len_sat", len_bus[15:8], DEPTH);
      drain(1); drain(0);

      // Random traffic.
      for (int it = 0; it < 40; it++) begin
         int ch;
         ch = $urandom_range(0, 2);
         if (tx_q[ch].size() < 8) wr(3'(1 << ch), 8'($urandom));
         wr_end();
         repeat ($urandom_range(0, 40)) @(negedge clk);
      end
      wait_idle();
      for (int c = 0; c < 3; c++) drain(c);
      check("e_len_all", len_bus, 0);

      // Reset mid-byte.
      for (int b = 0; b < 3; b++) wr(3'b001, 8'($urandom));
      wr_end();
      repeat (50) @(negedge clk);
      check("f_pre_cs", n_cs_bus, 3'b110);
      check("f_pre_len", len_bus[7:0], rx_q[0].size());
      n_rst = 1'b1;
      #1;
      check("f_sclk", sclk, 0);
      check("f_mosi", mosi, 0);
      check("f_ncs", n_cs_bus, 3'b111);
      check("f_sel", my_select, 0);
      check("f_len", len_bus, 0);
      check("f_have", have_msg_bus, 0);
      check("f_dout", s_dout_bus, 0);
      for (int c = 0; c < 3; c++) begin
         tx_q[c].delete();
         rx_q[c].delete();
      end
      repeat (3) @(negedge clk);
      n_rst = 1'b0;
      repeat (5) @(negedge clk);
      check("f_post_ncs", n_cs_bus, 3'b111);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/spi_multi.md
# spi_multi

Multi-channel SPI master that shares one SCLK/MOSI/MISO bus among three slaves, each with its own active-low chip select. Per channel, a host-side TX FIFO collects bytes to send and an RX FIFO collects the bytes clocked back from the slave. It sits between the internal byte-stream host logic and the board-level SPI peripherals.

## Interface
- N_CH, 3: number of slave channels.
- W, 8: byte width.
- DEPTH, 16: entries per TX and per RX FIFO (power of two).
- HALF, 2: clk cycles per SCLK half-period (SCLK = clk/(2·HALF)).
- clk  in  1  system clock; all logic on rising edge.
- n_rst  in  1  reset, asynchronous, active-high (1 = reset, despite the name).
- m_din  in  W  byte to transmit, shared by all channels.
- m_wrreq_bus  in  N_CH  per-channel write strobe; bit i pushes m_din into TX FIFO i.
- s_dout_bus  out  N_CH·W  RX FIFO heads; channel i at [W·i +: W], first-word-fall-through.
- len_bus  out  N_CH·W  RX FIFO fill counts; channel i at [W·i +: W].
- have_msg_bus  out  N_CH  bit i = RX FIFO i non-empty and channel i not in an active transfer.
- s_rdreq_bus  in  N_CH  per-channel pop strobe for RX FIFO i.
- sclk  out  1  SPI clock, idle low.
- mosi  out  1  SPI data out, MSB first.
- miso  in  1  SPI data in.
- n_cs_bus  out  N_CH  active-low chip selects; at most one low.
- my_select  out  2  index of the channel currently/last selected.

## Operation
- SPI mode 0: mosi updated on SCLK falling edge (first bit set up when n_cs falls); miso sampled on SCLK rising edge; MSB first; 8 bits/byte.
- FSM: IDLE → SELECT → SHIFT → HOLD → GAP → IDLE.
  - IDLE: if any TX FIFO non-empty, choose a channel round-robin starting after my_select; latch it into my_select; go to SELECT.
  - SELECT: drive n_cs_bus[sel] low, pop first TX byte into shift register, wait HALF cycles.
  - SHIFT: 16 half-periods per byte. After the 8th rising edge, push the received byte into RX FIFO sel. At the byte boundary, if TX FIFO sel is non-empty, pop the next byte and continue back-to-back with no gap; otherwise go to HOLD.
  - HOLD: SCLK low for HALF cycles, then n_cs high.
  - GAP: n_cs high for 2·HALF cycles, then IDLE.
- have_msg_bus[i] is forced low while channel i is selected (SELECT..HOLD).
- TX write to a full FIFO is dropped. An RX byte arriving at a full FIFO is dropped. A pop from an empty FIFO is ignored.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged.
- Writes to the active channel during SHIFT extend the same transaction if they land before the byte boundary.

## Timing
- Reset values: sclk=0, mosi=0, n_cs_bus=all 1, my_select=0, len_bus=0, have_msg_bus=0, FIFOs empty, s_dout_bus=0. Reset mid-transfer aborts the transfer immediately.
- Write latency: TX byte is visible to the arbiter the cycle after m_wrreq.
- Transfer start: n_cs falls ≤3 clk after the first write to an idle block.
- s_dout reflects the new head 1 cycle after s_rdreq; len updates 1 cycle after a push or pop.
- Byte period: 16·HALF clk.

## Structure
- Shared package: N_CH, W, DEPTH, HALF defaults and the FSM state enum.
- One sub-module: sfifo (sync FWFT FIFO with count output), instantiated 2·N_CH times.

## Test plan
- Reset, then write 01..06 to channel 1 on consecutive cycles -> n_cs_bus=3'b101 for one continuous 48-SCLK burst; mosi carries 01..06 MSB first; my_select=1.
- Random miso during the above -> after n_cs rises, have_msg_bus[1]=1, len ch1=6; pulse s_rdreq[1] for 6 cycles -> s_dout ch1 returns the sampled bytes in order; len ends at 0; have_msg_bus[1]=0.
- Write 0A..0D to ch2 while ch1 is busy -> ch2 is served after the ch1 GAP; n_cs never low on two channels at once.
- Writes to ch0 and ch2 in the same cycle while idle, my_select=1 -> ch2 is served first, then ch0.
- Write DEPTH+1 bytes to one channel before the transfer drains -> extra byte dropped; RX overflow is likewise dropped and len saturates at DEPTH.
- Assert n_rst mid-byte -> all outputs return to reset values immediately.
